arbitro_wrr: RTL and testbench
==============================

Name: arbitro_wrr

Overview:
- Parametrised successor to the fixed 4-channel arbiter stage.
- Pops NUM_CH input FIFOs with per-channel programmable weighted round-robin, and routes each returned word to one of NUM_CH output FIFOs by its destination field.
- Gates arbitration on output almost-full back-pressure.
- Keeps per-output push counters and a drop counter for words with an out-of-range destination.

Parameters:
- DATA_SIZE, 12, word width.
- NUM_CH, 4, number of input channels and output channels (2..8).
- DEST_W, 2, width of the destination field; must satisfy 2**DEST_W >= NUM_CH.
- DEST_LSB, 8, bit position of the destination field LSB in data_in.
- WEIGHT_W, 3, width of each channel weight.
- CNT_W, 5, width of each push counter and of the drop counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- weights  input  NUM_CH*WEIGHT_W  channel i weight in bits [i*WEIGHT_W +: WEIGHT_W]; 0 = channel disabled.
- fifo_empty  input  NUM_CH  input FIFO empty flags.
- fifo_af  input  NUM_CH  output FIFO almost-full flags.
- in_valid  input  1  data_in holds a popped word (one cycle after pop).
- data_in  input  DATA_SIZE  popped word.
- cnt_clr  input  1  synchronous clear of all counters.
- pop  output  NUM_CH  registered one-hot pop strobes.
- push  output  NUM_CH  combinational one-hot push strobes.
- data_out  output  DATA_SIZE  word to output FIFOs.
- cont  output  NUM_CH*CNT_W  per-output push counters.
- drop_cnt  output  CNT_W  dropped-word counter.
- idle  output  1  registered; 1 when no pop issued this cycle.

Behaviour:
- Reset (async, reset_L=0): pop=0, cont=0, drop_cnt=0, idle=1, cur=0, credit=0, state=SELECT.
- While in reset, push=0 and data_out=0 regardless of inputs.
- stall = |fifo_af. req[i] = !fifo_empty[i] && weight[i]!=0.
- State SELECT:
  - If stall or req==0: stay; pop=0.
  - Else: pick the first i with req[i], searching cyclically from cur+1 mod NUM_CH. The search includes cur itself last.
  - Load cur=i and credit=weight[i]; go to SERVE. No pop this cycle.
- State SERVE:
  - If stall: pop=0; hold cur and credit. Credit is not reset, unlike the previous generation.
  - Else if req[cur] && credit!=0: pop[cur]=1 next cycle; credit--. If credit becomes 0, go to SELECT.
  - Else (current channel empty or disabled): pop=0; go to SELECT. Remaining credit is forfeited.
- Pop timing:
  - pop is a single-cycle registered pulse.
  - Back-to-back pops of the same channel are allowed.
  - At most one pop bit is high per cycle.
  - idle = ~|pop.
- Weights are sampled only on entry to SERVE. A change mid-burst takes effect on the next selection.
- Datapath is combinational:
  - dest = data_in[DEST_LSB +: DEST_W].
  - If in_valid && dest<NUM_CH: push[dest]=1 and data_out=data_in.
  - Otherwise push=0 and data_out=0.
- Push is not gated by fifo_af. The system guarantees fifo_af asserts with at least 2 free entries, so the one in-flight word always fits.
- Out-of-range dest with in_valid=1: word dropped; drop_cnt increments.
- Counters:
  - cont[d] increments on each push[d] and wraps modulo 2**CNT_W.
  - drop_cnt wraps likewise.
  - cnt_clr=1 zeroes all counters that cycle and has priority over increments.
- Reset mid-burst: pop is forced low asynchronously. An in-flight word after reset release is pushed normally if in_valid is asserted.

Test Plan:
- Weights 4,3,2,1, all inputs non-empty, no af, 40 cycles → pop sequence 0000 111 22 3 repeats, with one idle cycle between bursts; after 2 rounds cont = 8,6,4,2 when data_in dest mirrors source.
- Weight[1]=0, others 1, all non-empty → channel 1 never popped; order 0,2,3,0,...
- fifo_af[2]=1 for 5 cycles mid-burst on channel 0 (credit 2 left) → no pops during stall; exactly 2 more pops of channel 0 follow, then the next channel.
- Channel 0 empties after 1 of 4 pops → SELECT moves to channel 1; leftover credit discarded.
- NUM_CH=3, in_valid with dest=3 → push=0, data_out=0, drop_cnt 0→1.
- 33 pushes to output 0 with CNT_W=5 → cont[0]=1. Assert cnt_clr together with a push → cont[0]=0. Assert reset_L=0 mid-SERVE → pop=0 immediately, all counters 0.

Source files
------------

// File: rtl/arbitro_wrr.sv
// arbitro_wrr: weighted round-robin pop arbiter over NUM_CH input FIFOs with a
// destination-routed push datapath into NUM_CH output FIFOs. Arbitration stalls
// on any output almost-full; per-output push counters and a drop counter for
// words whose destination field names no existing output.
module arbitro_wrr #(
    parameter int DATA_SIZE = 12,
    parameter int NUM_CH    = 4,
    parameter int DEST_W    = 2,
    parameter int DEST_LSB  = 8,
    parameter int WEIGHT_W  = 3,
    parameter int CNT_W     = 5
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic [NUM_CH*WEIGHT_W-1:0]  weights,
    input  logic [NUM_CH-1:0]           fifo_empty,
    input  logic [NUM_CH-1:0]           fifo_af,
    input  logic                        in_valid,
    input  logic [DATA_SIZE-1:0]        data_in,
    input  logic                        cnt_clr,
    output logic [NUM_CH-1:0]           pop,
    output logic [NUM_CH-1:0]           push,
    output logic [DATA_SIZE-1:0]        data_out,
    output logic [NUM_CH*CNT_W-1:0]     cont,
    output logic [CNT_W-1:0]            drop_cnt,
    output logic                        idle
);

    localparam int CUR_W = $clog2(NUM_CH);

    typedef enum logic {
        SELECT,
        SERVE
    } state_t;

    state_t                          state;
    logic [CUR_W-1:0]                cur;
    logic [WEIGHT_W-1:0]             credit;
    logic [WEIGHT_W-1:0]             weight [NUM_CH];
    logic [NUM_CH-1:0]               req;
    logic                            stall;
    logic [CUR_W-1:0]                next_ch;
    logic [DEST_W-1:0]               dest;
    logic                            dest_ok;
    logic                            drop;
    logic [NUM_CH-1:0][CNT_W-1:0]    cont_q;
    logic [CNT_W-1:0]                drop_q;

    // Channel reached by stepping 'off' positions forward from 'base', modulo NUM_CH.
    function automatic logic [CUR_W-1:0] ch_after(input logic [CUR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CUR_W'(s);
    endfunction

    assign stall = |fifo_af;

    // Unpack the weight bus and form the per-channel request vector.
    always_comb begin
        // NOTE: every combinational output gets a default before any conditional
        // assignment, so no path through the block can leave a latch behind.
        req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            weight[i] = weights[i*WEIGHT_W +: WEIGHT_W];
            req[i]    = !fifo_empty[i] && (weight[i] != '0);
        end
    end

    // Cyclic search starting at cur+1; cur itself has the lowest priority.
    // Walking from the farthest candidate to the nearest lets the nearest win.
    always_comb begin
        next_ch = cur;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req[ch_after(cur, k)]) next_ch = ch_after(cur, k);
        end
    end

    // Arbiter FSM: SELECT picks a channel and loads its credit, SERVE spends it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= SELECT;
            cur    <= '0;
            credit <= '0;
            pop    <= '0;
            idle   <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            pop  <= '0;
            idle <= 1'b1;
            case (state)
                SELECT: begin
                    if (!stall && (|req)) begin
                        cur    <= next_ch;
                        credit <= weight[next_ch];
                        state  <= SERVE;
                    end
                end
                SERVE: begin
                    // A stall freezes cur and credit; the burst resumes where it left off.
                    if (!stall) begin
                        if (req[cur] && (credit != '0)) begin
                            pop    <= NUM_CH'(1) << cur;
                            idle   <= 1'b0;
                            credit <= credit - WEIGHT_W'(1);
                            if (credit == WEIGHT_W'(1)) state <= SELECT;
                        end else begin
                            // Channel went empty or was disabled: leftover credit is lost.
                            state <= SELECT;
                        end
                    end
                end
                default: state <= SELECT;
            endcase
        end
    end

    assign dest    = data_in[DEST_LSB +: DEST_W];
    assign dest_ok = int'(dest) < NUM_CH;

    // Route the returned word by its destination field; held quiet during reset.
    always_comb begin
        push     = '0;
        data_out = '0;
        drop     = 1'b0;
        if (reset_L && in_valid) begin
            if (dest_ok) begin
                push     = NUM_CH'(1) << dest;
                data_out = data_in;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Push and drop counters; clear wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cont_q <= '0;
            drop_q <= '0;
        end else if (cnt_clr) begin
            cont_q <= '0;
            drop_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) cont_q[i] <= cont_q[i] + CNT_W'(1);
            end
            if (drop) drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign cont     = cont_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_arbitro_wrr.sv
// tb_arbitro_wrr: directed scenarios followed by random traffic, every cycle
// compared against a burst-level model of weighted round-robin and routing.
module tb_arbitro_wrr;

    localparam int NCH      = 4;
    localparam int DW       = 12;
    localparam int DEST_W   = 3;
    localparam int DEST_LSB = 8;
    localparam int WW       = 3;
    localparam int CW       = 5;

    logic              clk = 1'b0;
    logic              reset_L;
    logic [NCH*WW-1:0] weights;
    logic [NCH-1:0]    fifo_empty;
    logic [NCH-1:0]    fifo_af;
    logic              in_valid;
    logic [DW-1:0]     data_in;
    logic              cnt_clr;
    logic [NCH-1:0]    pop;
    logic [NCH-1:0]    push;
    logic [DW-1:0]     data_out;
    logic [NCH*CW-1:0] cont;
    logic [CW-1:0]     drop_cnt;
    logic              idle;

    int checks = 0;
    int errors = 0;

    // Reference model: which channel owns the current burst and how many pops remain.
    bit             m_serving;
    int             m_ch;
    int             m_credit;
    logic [NCH-1:0] m_pop;
    int             m_cont [NCH];
    int             m_drop;
    bit             mirror;

    arbitro_wrr #(
        .DATA_SIZE(DW), .NUM_CH(NCH), .DEST_W(DEST_W),
        .DEST_LSB(DEST_LSB), .WEIGHT_W(WW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_L(reset_L), .weights(weights),
        .fifo_empty(fifo_empty), .fifo_af(fifo_af), .in_valid(in_valid),
        .data_in(data_in), .cnt_clr(cnt_clr), .pop(pop), .push(push),
        .data_out(data_out), .cont(cont), .drop_cnt(drop_cnt), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wt(input int i);
        return int'(weights[i*WW +: WW]);
    endfunction

    function automatic bit wants(input int i);
        return !fifo_empty[i] && (wt(i) != 0);
    endfunction

    function automatic int cont_of(input int i);
        return int'(cont[i*CW +: CW]);
    endfunction

    task automatic model_reset();
        m_serving = 1'b0;
        m_ch      = 0;
        m_credit  = 0;
        m_pop     = '0;
        m_drop    = 0;
        for (int i = 0; i < NCH; i++) m_cont[i] = 0;
    endtask

    // What the next rising edge does, from the rules stated in words.
    task automatic model_edge();
        bit             stalled;
        int             base;
        int             c;
        int             d;
        bit             found;
        logic [NCH-1:0] np;
        stalled = |fifo_af;
        np      = '0;
        if (!m_serving) begin
            if (!stalled) begin
                base  = m_ch;
                found = 1'b0;
                for (int k = 1; k <= NCH; k++) begin
                    c = (base + k) % NCH;
                    if (!found && wants(c)) begin
                        found     = 1'b1;
                        m_ch      = c;
                        m_credit  = wt(c);
                        m_serving = 1'b1;
                    end
                end
            end
        end else if (!stalled) begin
            if (wants(m_ch) && m_credit > 0) begin
                np[m_ch] = 1'b1;
                m_credit--;
                if (m_credit == 0) m_serving = 1'b0;
            end else begin
                m_serving = 1'b0;
            end
        end
        m_pop = np;
        if (cnt_clr) begin
            for (int i = 0; i < NCH; i++) m_cont[i] = 0;
            m_drop = 0;
        end else if (in_valid) begin
            d = int'(data_in[DEST_LSB +: DEST_W]);
            if (d < NCH) m_cont[d] = (m_cont[d] + 1) % (1 << CW);
            else         m_drop    = (m_drop + 1) % (1 << CW);
        end
    endtask

    task automatic check_comb();
        logic [NCH-1:0] ep;
        logic [DW-1:0]  ed;
        int             d;
        ep = '0;
        ed = '0;
        d  = int'(data_in[DEST_LSB +: DEST_W]);
        if (reset_L && in_valid && d < NCH) begin
            ep[d] = 1'b1;
            ed    = data_in;
        end
        check("push", push, ep);
        check("data_out", data_out, ed);
    endtask

    task automatic check_regs();
        check("pop", pop, m_pop);
        check("idle", idle, m_pop == '0);
        for (int i = 0; i < NCH; i++) check($sformatf("cont%0d", i), cont_of(i), m_cont[i]);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    // Return the popped word on the next cycle, tagged with its source channel.
    task automatic drive_mirror();
        int idx;
        idx = -1;
        for (int i = 0; i < NCH; i++) if (m_pop[i]) idx = i;
        in_valid = (idx >= 0);
        data_in  = 12'($urandom);
        if (idx >= 0) data_in[DEST_LSB +: DEST_W] = 3'(idx);
    endtask

    // One clock: combinational check before the edge, registered check after it.
    task automatic tick();
        #1;
        check_comb();
        @(posedge clk);
        if (reset_L) model_edge();
        else         model_reset();
        @(negedge clk);
        check_regs();
        if (mirror) drive_mirror();
    endtask

    task automatic wait_burst(input int ch, input int cr, input int budget, input string tag);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            if (m_serving && m_ch == ch && m_credit == cr) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    initial begin
        int             n0;
        int             n1;
        int             nother;
        int             stalled_pops;
        logic [NCH-1:0] nxt;
        bit             seen;

        weights    = {3'd1, 3'd2, 3'd3, 3'd4};
        fifo_empty = '0;
        fifo_af    = '0;
        in_valid   = 1'b1;
        data_in    = 12'h0AB;
        cnt_clr    = 1'b0;
        mirror     = 1'b0;
        reset_L    = 1'b1;
        model_reset();

        // Reset state, with a valid in-range word present on the input.
        #1 reset_L = 1'b0;
        #1;
        check("rst_pop", pop, '0);
        check("rst_idle", idle, 1'b1);
        check("rst_cont", cont, '0);
        check("rst_drop", drop_cnt, '0);
        check("rst_push", push, '0);
        check("rst_data_out", data_out, '0);
        @(negedge clk);
        repeat (2) tick();

        // Weights 4,3,2,1, everything non-empty, word destination mirrors source.
        in_valid = 1'b0;
        reset_L  = 1'b1;
        mirror   = 1'b1;
        repeat (29) tick();
        check("round_cont0", cont_of(0), 8);
        check("round_cont1", cont_of(1), 6);
        check("round_cont2", cont_of(2), 4);
        check("round_cont3", cont_of(3), 2);

        // Stall for 5 cycles while channel 0 still has 2 credits.
        wait_burst(0, 2, 40, "wait_ch0_cr2");
        fifo_af      = 4'b0100;
        stalled_pops = 0;
        repeat (5) begin
            tick();
            if (pop != '0) stalled_pops++;
        end
        check("stall_no_pop", stalled_pops, 0);
        fifo_af = '0;
        n0      = 0;
        nxt     = '0;
        for (int i = 0; i < 20 && nxt == '0; i++) begin
            tick();
            if (pop == 4'b0001) n0++;
            else if (pop != '0) nxt = pop;
        end
        check("stall_ch0_after", n0, 2);
        check("stall_next_ch", nxt, 4'b0010);

        // Channel 0 runs dry after one of its four pops.
        wait_burst(0, 3, 60, "wait_ch0_cr3");
        fifo_empty = 4'b0001;
        nxt        = '0;
        for (int i = 0; i < 10 && nxt == '0; i++) begin
            tick();
            if (pop != '0) nxt = pop;
        end
        check("empty_next_ch", nxt, 4'b0010);
        fifo_empty = '0;

        // Channel 1 disabled by weight 0, others weight 1.
        weights = {3'd1, 3'd1, 3'd0, 3'd1};
        n1      = 0;
        nother  = 0;
        repeat (30) begin
            tick();
            if (pop == 4'b0010) n1++;
            else if (pop != '0) nother++;
        end
        check("disabled_ch1", n1, 0);
        check("disabled_others_pop", nother >= 6, 1'b1);

        // Datapath with a quiet arbiter: out-of-range destination, then wrap.
        mirror   = 1'b0;
        weights  = '0;
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b1;
        data_in  = 12'h5CD;
        #1;
        check("drop_push", push, '0);
        check("drop_data_out", data_out, '0);
        tick();
        check("drop_cnt_one", drop_cnt, 5'd1);
        data_in = 12'h03C;
        repeat (33) tick();
        check("wrap_cont0", cont_of(0), 1);
        cnt_clr = 1'b1;
        tick();
        check("clr_cont0", cont_of(0), 0);
        check("clr_drop", drop_cnt, '0);
        cnt_clr  = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a burst.
        weights  = {3'd1, 3'd2, 3'd3, 3'd4};
        in_valid = 1'b1;
        data_in  = 12'h300;
        repeat (3) tick();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (m_pop != '0) seen = 1'b1;
            else tick();
        end
        check("wait_pop_before_rst", seen, 1'b1);
        reset_L = 1'b0;
        #1;
        check("midrst_pop", pop, '0);
        check("midrst_idle", idle, 1'b1);
        check("midrst_cont", cont, '0);
        check("midrst_drop", drop_cnt, '0);
        check("midrst_push", push, '0);
        model_reset();
        tick();
        reset_L = 1'b1;
        data_in = 12'h2AA;
        tick();
        check("post_rst_cont2", cont_of(2), 1);
        in_valid = 1'b0;

        // Random traffic.
        repeat (300) begin
            if ($urandom_range(0, 19) == 0) weights = 12'($urandom);
            fifo_empty = 4'($urandom) & 4'($urandom);
            fifo_af    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            in_valid   = 1'($urandom);
            data_in    = 12'($urandom);
            cnt_clr    = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
